// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encoding and the LFSR/SISR polynomial constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bist_pkg;

  localparam int unsigned BIST_SIG_W = 8;
  localparam logic [BIST_SIG_W-1:0] BIST_POLY = 8'h8E;
  localparam logic [BIST_SIG_W-1:0] BIST_SEED = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/bist_sisr_core.sv
// Serial-input signature register: shifts left, feeding back tap parity XOR din into bit 0.
// Latency: sig reflects a load/shift on the edge after it is requested.
// Backpressure: none; steps only when shift=1, load wins over shift.
module bist_sisr_core #(
  parameter int unsigned     SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY = 8'h8E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [SIG_W-1:0] seed,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic             fb;

  // Next signature: reload seed, take one compaction step, or hold.
  always_comb begin
    fb    = (^(sig_q & POLY)) ^ din;
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (shift) begin
      sig_d = {sig_q[SIG_W-2:0], fb};
    end
  end

  // Signature register; reset returns it to the seed value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST response analyzer: compacts num_bits scan bits into a SISR signature and compares to golden.
// Latency: done/pass visible two edges after the final accepted d_clk step.
// Backpressure: none; d_clk steps are ignored outside RUN or once the count is reached. Optional abort input under BIST_ABORT_EN.
module bist_signature_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W = BIST_SIG_W,
  parameter int unsigned      CNT_W = 8,
  parameter logic [SIG_W-1:0] POLY  = BIST_POLY,
  parameter logic [SIG_W-1:0] SEED  = BIST_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_clk,
  input  logic             start,
  input  logic             scan_bit,
  input  logic [CNT_W-1:0] num_bits,
  input  logic [SIG_W-1:0] golden,
`ifdef BIST_ABORT_EN
  input  logic             abort,
`endif
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             sisr_load;
  logic             sisr_shift;
  logic [SIG_W-1:0] sig;

  bist_sisr_core #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_sisr (
    .clk   (clk),
    .rst   (rst),
    .load  (sisr_load),
    .shift (sisr_shift),
    .seed  (SEED),
    .din   (scan_bit),
    .sig   (sig)
  );

  // Next-state and control: count check precedes the shift so the counter never passes num_bits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbits_d    = nbits_q;
    done_d     = done_q;
    pass_d     = pass_q;
    sisr_load  = 1'b0;
    sisr_shift = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          sisr_load = 1'b1;
          cnt_d     = '0;
          nbits_d   = num_bits;
          pass_d    = 1'b0;
          done_d    = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == nbits_q) begin
          state_d = CHECK;
        end else if (d_clk) begin
          sisr_shift = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        pass_d  = (sig == golden);
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
`ifdef BIST_ABORT_EN
    // Abort drops back to IDLE but leaves signature and count visible for debug.
    if (abort && (state_q == RUN || state_q == CHECK)) begin
      state_d    = IDLE;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      sisr_shift = 1'b0;
      sisr_load  = 1'b0;
    end
`endif
  end

  // State, counter, latched length and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nbits_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nbits_q <= nbits_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign signature = sig;
  assign bit_count = cnt_q;
  assign busy      = (state_q == RUN) || (state_q == CHECK);
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
module tb_bist_signature_analyzer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d_clk = 1'b0;
  logic       start = 1'b0;
  logic       scan_bit = 1'b0;
  logic [7:0] num_bits = 8'd0;
  logic [7:0] golden = 8'd0;
`ifdef BIST_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [7:0] signature;
  logic [7:0] bit_count;
  logic       busy;
  logic       done;
  logic       pass;

  int n_pass = 0;
  int n_total = 0;

  // Hand-derived SISR states for scan bits 1,0,0,0 from seed 8'h00, poly 8'h8E.
  logic [7:0] exp_sig [4] = '{8'h01, 8'h02, 8'h05, 8'h0B};
  logic [3:0] stim_bits = 4'b0001;

  always #5 clk = ~clk;

  bist_signature_analyzer dut (
    .clk       (clk),
    .rst       (rst),
    .d_clk     (d_clk),
    .start     (start),
    .scan_bit  (scan_bit),
    .num_bits  (num_bits),
    .golden    (golden),
`ifdef BIST_ABORT_EN
    .abort     (abort),
`endif
    .signature (signature),
    .bit_count (bit_count),
    .busy      (busy),
    .done      (done),
    .pass      (pass)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic b);
    d_clk = 1'b1;
    scan_bit = b;
    tick();
    d_clk = 1'b0;
    scan_bit = 1'b0;
  endtask

  task automatic kick(input logic [7:0] n, input logic [7:0] g);
    num_bits = n;
    golden = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_total++; if (signature !== 8'h00) $display("FAIL reset_sig got %h want 00", signature); else n_pass++;
    n_total++; if (bit_count !== 8'd0) $display("FAIL reset_cnt got %0d want 0", bit_count); else n_pass++;
    n_total++; if ({busy, done, pass} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, pass}); else n_pass++;
  endtask

  task automatic test_basic_pass();
    kick(8'd4, 8'h0B);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_run got %b want 1", busy); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pulse(stim_bits[i]);
      n_total++;
      if (signature !== exp_sig[i] || bit_count !== 8'(i + 1))
        $display("FAIL basic_step%0d got sig %h cnt %0d want %h %0d", i, signature, bit_count, exp_sig[i], i + 1);
      else n_pass++;
    end
    tick();
    n_total++; if ({busy, done} !== 2'b10) $display("FAIL basic_check_state got busy,done %b want 10", {busy, done}); else n_pass++;
    tick();
    n_total++; if ({busy, done, pass} !== 3'b011) $display("FAIL basic_done got busy,done,pass %b want 011", {busy, done, pass}); else n_pass++;
  endtask

  task automatic test_restart_mismatch();
    kick(8'd4, 8'h0A);
    n_total++; if ({done, pass, busy} !== 3'b001 || signature !== 8'h00) $display("FAIL restart got dpb %b sig %h want 001 00", {done, pass, busy}, signature); else n_pass++;
    for (int i = 0; i < 4; i++) pulse(stim_bits[i]);
    tick();
    tick();
    n_total++; if ({done, pass} !== 2'b10 || signature !== 8'h0B) $display("FAIL mismatch got dp %b sig %h want 10 0b", {done, pass}, signature); else n_pass++;
  endtask

  task automatic test_extra_dclk();
    kick(8'd4, 8'h0B);
    for (int i = 0; i < 4; i++) pulse(stim_bits[i]);
    pulse(1'b1);
    pulse(1'b1);
    n_total++; if (done !== 1'b1 || pass !== 1'b1) $display("FAIL extra_done got dp %b want 11", {done, pass}); else n_pass++;
    pulse(1'b1);
    pulse(1'b0);
    n_total++; if (signature !== 8'h0B || bit_count !== 8'd4) $display("FAIL extra_hold got sig %h cnt %0d want 0b 4", signature, bit_count); else n_pass++;
  endtask

  task automatic test_start_in_run();
    kick(8'd4, 8'h0B);
    pulse(1'b1);
    start = 1'b1;
    pulse(1'b0);
    start = 1'b0;
    n_total++; if (signature !== 8'h02 || bit_count !== 8'd2 || busy !== 1'b1) $display("FAIL start_in_run got sig %h cnt %0d busy %b want 02 2 1", signature, bit_count, busy); else n_pass++;
    pulse(1'b0);
    pulse(1'b0);
    tick();
    tick();
    n_total++; if (signature !== 8'h0B || done !== 1'b1 || pass !== 1'b1) $display("FAIL start_in_run_end got sig %h dp %b want 0b 11", signature, {done, pass}); else n_pass++;
  endtask

  task automatic test_zero_bits();
    num_bits = 8'd0;
    golden = 8'h00;
    start = 1'b1;
    d_clk = 1'b1;
    scan_bit = 1'b1;
    tick();
    start = 1'b0;
    d_clk = 1'b0;
    scan_bit = 1'b0;
    n_total++; if (signature !== 8'h00 || bit_count !== 8'd0 || busy !== 1'b1) $display("FAIL zero_start got sig %h cnt %0d busy %b want 00 0 1", signature, bit_count, busy); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL zero_early_done got %b want 0", done); else n_pass++;
    tick();
    n_total++; if ({busy, done, pass} !== 3'b011 || signature !== 8'h00) $display("FAIL zero_done got bdp %b sig %h want 011 00", {busy, done, pass}, signature); else n_pass++;
  endtask

  task automatic test_mid_reset();
    kick(8'd4, 8'h0B);
    pulse(1'b1);
    pulse(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (signature !== 8'h00 || bit_count !== 8'd0 || {busy, done, pass} !== 3'b000) $display("FAIL mid_reset got sig %h cnt %0d bdp %b want 00 0 000", signature, bit_count, {busy, done, pass}); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL mid_reset_idle got busy %b want 0", busy); else n_pass++;
  endtask

`ifdef BIST_ABORT_EN
  task automatic test_abort();
    kick(8'd4, 8'h0B);
    pulse(1'b1);
    pulse(1'b0);
    abort = 1'b1;
    d_clk = 1'b1;
    tick();
    abort = 1'b0;
    d_clk = 1'b0;
    n_total++; if (signature !== 8'h02 || bit_count !== 8'd2 || {busy, done, pass} !== 3'b000) $display("FAIL abort got sig %h cnt %0d bdp %b want 02 2 000", signature, bit_count, {busy, done, pass}); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_pass();
    test_restart_mismatch();
    test_extra_dclk();
    test_start_in_run();
    test_zero_bits();
    test_mid_reset();
`ifdef BIST_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
